// File: rtl/scaler_h_mc.sv
// Multi-channel horizontal scaler: resamples each line by a 4.12 step using
// nearest or linear interpolation, with a 3-stage arithmetic/sync pipeline.
module scaler_h_mc #(
  parameter int CH_COUNT      = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int LINE_SIZE_MAX = 4096,
  parameter int STEP_MIN      = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    step_cord_o,
  input  logic                           mode_i,
  input  logic [CH_COUNT*DATA_WIDTH-1:0] di_i,
  input  logic                           de_i,
  input  logic                           hs_i,
  input  logic                           vs_i,
  output logic [CH_COUNT*DATA_WIDTH-1:0] do_o,
  output logic                           de_o,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic [15:0]                    pix_count_o,
  output logic                           ovf_o
);

  localparam int CW = $clog2(LINE_SIZE_MAX) + 1;
  localparam int AW = CW + 12;
  localparam int PW = DATA_WIDTH + 13;
  localparam int DW = CH_COUNT * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_GEN} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_step;
  logic          r_mode;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic [15:0]   r_kcnt;
  logic [DW-1:0] r_p0;
  logic [DW-1:0] r_p1;
  logic          r_hs_pend;
  logic [15:0]   r_pix_count;
  logic          r_ovf;

  logic          w_start;
  logic          w_capture;
  logic          w_issue;
  logic          w_drop;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_ip;
  logic [AW-1:0] w_acc_inc;
  logic [CW-1:0] w_ip_inc;
  logic          w_full;
  logic [15:0]   w_kcnt_next;

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_ip        = CW'(r_acc >> 12);
  assign w_acc_inc   = r_acc + {{(AW-16){1'b0}}, r_step};
  assign w_ip_inc    = CW'(w_acc_inc >> 12);
  assign w_full      = (r_cnt == CW'(LINE_SIZE_MAX));
  assign w_kcnt_next = w_issue ? (r_kcnt + 16'd1) : r_kcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // r_cnt counts captured pixels, so the newest pixel has index r_cnt-1 and
  // an output at ip needs pixels ip and ip+1, i.e. ip == count-2.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_issue      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!hs_i) begin
          w_start      = 1'b1;
          w_state_next = S_LINE;
        end
      end
      S_LINE: begin
        if (de_i) begin
          if (w_full) begin
            w_drop = 1'b1;
          end else begin
            w_capture = 1'b1;
            if (w_cnt_inc >= CW'(2) && w_ip == w_cnt_inc - CW'(2))
              w_state_next = S_GEN;
          end
        end else if (hs_i) begin
          w_state_next = S_IDLE;
        end
      end
      S_GEN: begin
        w_issue = 1'b1;
        w_drop  = de_i;
        if (w_ip_inc != r_cnt - CW'(2))
          w_state_next = (r_hs_pend || hs_i) ? S_IDLE : S_LINE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step      <= 16'd0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_kcnt      <= 16'd0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_hs_pend   <= 1'b0;
      r_pix_count <= 16'd0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_start) begin
        r_step    <= (step_cord_o < 16'(STEP_MIN)) ? 16'(STEP_MIN) : step_cord_o;
        r_mode    <= mode_i;
        r_cnt     <= '0;
        r_acc     <= '0;
        r_kcnt    <= 16'd0;
        r_hs_pend <= 1'b0;
      end
      if (r_state != S_IDLE && hs_i)
        r_hs_pend <= 1'b1;
      if (w_capture) begin
        r_p1  <= di_i;
        r_p0  <= r_p1;
        r_cnt <= w_cnt_inc;
      end
      if (w_issue) begin
        r_acc  <= w_acc_inc;
        r_kcnt <= w_kcnt_next;
      end
      if (w_drop)
        r_ovf <= 1'b1;
      if (r_state != S_IDLE && w_state_next == S_IDLE)
        r_pix_count <= w_kcnt_next;
    end
  end

  // Stage 1: snapshot of the issue cycle.
  logic [DW-1:0] r_s1_p0;
  logic [DW-1:0] r_s1_p1;
  logic [11:0]   r_s1_f;
  logic          r_s1_mode;
  logic          r_s1_de;
  logic          r_s1_hs;
  logic          r_s1_vs;
  logic          r_s2_mode;
  logic          r_s2_de;
  logic          r_s2_hs;
  logic          r_s2_vs;
  logic [DW-1:0] r_do;
  logic          r_de;
  logic          r_hs;
  logic          r_vs;
  logic [12:0]   w_fi;
  logic [DW-1:0] w_res;

  assign w_fi = 13'd4096 - {1'b0, r_s1_f};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_p0   <= '0;
      r_s1_p1   <= '0;
      r_s1_f    <= 12'd0;
      r_s1_mode <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s2_mode <= 1'b0;
      r_s2_de   <= 1'b0;
      r_s2_hs   <= 1'b1;
      r_s2_vs   <= 1'b1;
      r_do      <= '0;
      r_de      <= 1'b0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
    end else begin
      r_s1_p0   <= r_p0;
      r_s1_p1   <= r_p1;
      r_s1_f    <= r_acc[11:0];
      r_s1_mode <= r_mode;
      r_s1_de   <= w_issue;
      r_s1_hs   <= (r_state == S_IDLE);
      r_s1_vs   <= vs_i;
      r_s2_mode <= r_s1_mode;
      r_s2_de   <= r_s1_de;
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
      r_do      <= w_res;
      r_de      <= r_s2_de;
      r_hs      <= r_s2_hs;
      r_vs      <= r_s2_vs;
    end
  end

  // Stage 2 registers the weighted products; stage 3 rounds and selects.
  // The weights sum to 4096, so the rounded result never exceeds 8 bits.
  for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [PW-1:0]         r_m0;
    logic [PW-1:0]         r_m1;
    logic [DATA_WIDTH-1:0] r_near;
    logic [PW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0] w_lin;

    assign w_a   = r_s1_p0[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_b   = r_s1_p1[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_sum = r_m0 + r_m1 + PW'(2048);
    assign w_lin = DATA_WIDTH'(w_sum >> 12);
    assign w_res[gi*DATA_WIDTH +: DATA_WIDTH] = r_s2_mode ? w_lin : r_near;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_m0   <= '0;
        r_m1   <= '0;
        r_near <= '0;
      end else begin
        r_m0   <= PW'(w_a) * PW'(w_fi);
        r_m1   <= PW'(w_b) * PW'(r_s1_f);
        r_near <= r_s1_f[11] ? w_b : w_a;
      end
    end
  end

  assign do_o        = r_do;
  assign de_o        = r_de;
  assign hs_o        = r_hs;
  assign vs_o        = r_vs;
  assign pix_count_o = r_pix_count;
  assign ovf_o       = r_ovf;

endmodule
